ysyx_23060221_axi_uart_fifo: RTL and testbench
==============================================

YSYX_23060221_AXI_UART_FIFO -- requirements
Module: ysyx_23060221_axi_uart_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 64, AXI data width in bits (32 or 64).
REQ-002 SHALL have parameter ID_W, default 4, AXI ID width in bits.
REQ-003 SHALL have parameter TX_DEPTH, default 16, TX FIFO depth in bytes (power of 2, at least 2).
REQ-004 SHALL have parameter BAUD_DIV, default 4, number of cycles per drained byte (at least 1).
REQ-005 SHALL have parameter BASE, default 32'ha00003f8, TXDATA address; STATUS is at BASE+4.
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have the AXI4 write-address channel: awvalid/awready 1b, awaddr 32b, awid ID_W, awlen 8b, awsize 3b, awburst 2b.
REQ-009 SHALL have the AXI4 write-data channel: wvalid/wready 1b, wdata DATA_W, wstrb DATA_W/8, wlast 1b.
REQ-010 SHALL have the AXI4 write-response channel: bvalid/bready 1b, bresp 2b, bid ID_W.
REQ-011 SHALL have the AXI4 read-address channel: arvalid/arready 1b, araddr 32b, arid ID_W, arlen 8b, arsize 3b, arburst 2b.
REQ-012 SHALL have the AXI4 read-data channel: rvalid/rready 1b, rdata DATA_W, rresp 2b, rlast 1b, rid ID_W.
REQ-013 SHALL have port tx_strobe, output, 1 bit: one-cycle pulse when a byte leaves the FIFO.
REQ-014 SHALL have port tx_byte, output, 8 bits: the byte valid while tx_strobe is high.

Function
REQ-015 Write FSM SHALL use states W_IDLE, W_DATA and W_RESP: W_IDLE --(awvalid&awready)--> W_DATA; W_DATA --(wvalid&wready&wlast)--> W_RESP; W_RESP --(bvalid&bready)--> W_IDLE.
REQ-016 awready SHALL be 1 only in W_IDLE; awaddr and awid SHALL be latched on the AW handshake.
REQ-017 In W_DATA, when the latched address equals BASE, each beat SHALL push byte lane awaddr[log2(DATA_W/8)-1:0] into the FIFO if that lane's wstrb bit is 1.
REQ-018 In W_DATA, wready SHALL be 0 while the FIFO is full (backpressure; no push-through on a same-cycle pop).
REQ-019 Beats to other addresses SHALL be accepted and discarded.
REQ-020 In W_RESP, bvalid SHALL be 1 and bid SHALL equal the latched awid.
REQ-021 bresp SHALL be 2'b00 for BASE or BASE+4 and 2'b10 (SLVERR) for any other address.
REQ-022 Read FSM SHALL use states R_IDLE and R_DATA: arready is 1 only in R_IDLE; the AR handshake latches araddr, arid and arlen and clears the beat counter.
REQ-023 In R_DATA, rvalid SHALL be 1 and SHALL return exactly arlen+1 beats.
REQ-024 rlast SHALL be 1 on the beat where the beat counter equals the latched arlen (including arlen=0).
REQ-025 The read FSM SHALL return to R_IDLE after that beat completes with rready=1.
REQ-026 rdata SHALL carry STATUS in the lane of BASE+4: bit0 full, bit1 empty, bits[15:8] count; other lanes and the TXDATA lane SHALL read 0.
REQ-027 rresp SHALL follow the same OKAY/SLVERR rule as bresp; rid SHALL equal the latched arid.
REQ-028 The read and write FSMs SHALL operate independently and concurrently.
REQ-029 rdata SHALL be stable while rvalid=1 and rready=0.
REQ-030 Drain: a divider counter SHALL run only while the FIFO is non-empty.
REQ-031 Drain: at count BAUD_DIV-1 the FIFO SHALL pop, and tx_strobe=1 with tx_byte=head for one cycle; the counter then wraps to 0.
REQ-032 A simultaneous push and pop SHALL leave count unchanged.
REQ-033 Read and write pointers SHALL wrap modulo TX_DEPTH; count width SHALL be log2(TX_DEPTH)+1.

Reset
REQ-034 reset SHALL return both FSMs to IDLE and set awready=1, arready=1, and wready, bvalid, rvalid, rlast, tx_strobe = 0.
REQ-035 reset SHALL empty the FIFO (count 0, pointers 0) and clear the divider.
REQ-036 reset asserted mid-burst SHALL abort the burst without issuing a response.

Configuration
REQ-037 With UART_SIM_PRINT_EN defined, every tx_strobe cycle SHALL $write("%c", tx_byte).
REQ-038 Without UART_SIM_PRINT_EN, the block SHALL produce no simulation output and be fully synthesizable.

Structure
REQ-039 A shared package SHALL hold the FSM state typedefs, the AXI resp constants (OKAY, SLVERR) and the STATUS bit positions.
REQ-040 The FIFO SHALL be sub-module ysyx_23060221_sync_fifo (parameters WIDTH, DEPTH).

Verification
REQ-041 Single write 0x41 to BASE, wstrb lane set, BAUD_DIV=4 -> bresp=0; tx_strobe with tx_byte=0x41 within 4 cycles of the push.
REQ-042 Burst awlen=3 writing 'a','b','c','d' -> 4 beats accepted; bvalid only after wlast; bytes drained in order, 4 cycles apart.
REQ-043 TX_DEPTH=4 plus 6 pushes with no drain time -> wready=0 when full; all 6 bytes are eventually emitted with none lost.
REQ-044 Read BASE+4 with arlen=2 on an empty FIFO -> 3 beats with STATUS=0x0002 and rlast only on beat 3; rid echoes arid.
REQ-045 Write to 0xa0000000 -> bresp=2'b10 and the FIFO is unchanged.
REQ-046 Reset asserted during W_DATA -> all reset values from REQ-034/035; a following single write completes normally.

Source files
------------

// File: rtl/ysyx_23060221_axi_uart_fifo_pkg.sv
// ysyx_23060221_axi_uart_fifo_pkg: FSM state types, AXI response codes and STATUS register layout.
package ysyx_23060221_axi_uart_fifo_pkg;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int STAT_FULL = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_COUNT = 8;
endpackage

// File: rtl/ysyx_23060221_axi_uart_fifo_if.sv
// ysyx_23060221_axi_uart_fifo_if: AXI4 five-channel bundle with master/slave views.
interface ysyx_23060221_axi_uart_fifo_if #(
    parameter int DATA_W = 64,
    parameter int ID_W = 4
);
    logic awvalid;
    logic awready;
    logic [31:0] awaddr;
    logic [ID_W-1:0] awid;
    logic [7:0] awlen;
    logic [2:0] awsize;
    logic [1:0] awburst;
    logic wvalid;
    logic wready;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic wlast;
    logic bvalid;
    logic bready;
    logic [1:0] bresp;
    logic [ID_W-1:0] bid;
    logic arvalid;
    logic arready;
    logic [31:0] araddr;
    logic [ID_W-1:0] arid;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic rvalid;
    logic rready;
    logic [DATA_W-1:0] rdata;
    logic [1:0] rresp;
    logic rlast;
    logic [ID_W-1:0] rid;
    modport slave (
        input awvalid, awaddr, awid, awlen, awsize, awburst,
        input wvalid, wdata, wstrb, wlast, bready,
        input arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp, bid,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input awready, wready, bvalid, bresp, bid,
        input arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_23060221_sync_fifo.sv
// ysyx_23060221_sync_fifo: single-clock FIFO; callers must not push when full or pop when empty.
module ysyx_23060221_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input logic clk,
    input logic reset,
    input logic push,
    input logic [WIDTH-1:0] din,
    input logic pop,
    output logic [WIDTH-1:0] dout,
    output logic full,
    output logic empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push)
                wp <= wp + AW'(1);
            if (pop)
                rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/ysyx_23060221_axi_uart_fifo.sv
// ysyx_23060221_axi_uart_fifo: AXI4 slave feeding a byte TX FIFO drained at BAUD_DIV cycles per byte.
// Define UART_SIM_PRINT_EN to echo every drained byte to the simulator console.
module ysyx_23060221_axi_uart_fifo
    import ysyx_23060221_axi_uart_fifo_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ID_W = 4,
    parameter int TX_DEPTH = 16,
    parameter int BAUD_DIV = 4,
    parameter logic [31:0] BASE = 32'ha00003f8
) (
    input logic clk,
    input logic reset,
    ysyx_23060221_axi_uart_fifo_if.slave axi,
    output logic tx_strobe,
    output logic [7:0] tx_byte
);
    localparam int LB = $clog2(DATA_W / 8);
    localparam int CW = $clog2(TX_DEPTH) + 1;
    localparam int DW = BAUD_DIV > 1 ? $clog2(BAUD_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(BAUD_DIV - 1);
    localparam logic [31:0] STATUS = BASE + 32'd4;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [31:0] aw_addr, ar_addr;
    logic [ID_W-1:0] aw_id, ar_id;
    logic [7:0] ar_len, beat;
    logic [DATA_W-1:0] rdata_q;
    logic push, pop, full, empty;
    logic [CW-1:0] count;
    logic [DW-1:0] div;
    logic [15:0] status;
    logic unused;
    assign unused = ^{axi.awlen, axi.awsize, axi.awburst, axi.arsize, axi.arburst};
    function automatic logic [1:0] resp_of(input logic [31:0] a);
        return (a == BASE || a == STATUS) ? RESP_OKAY : RESP_SLVERR;
    endfunction
    function automatic logic [DATA_W-1:0] rd_val(input logic [31:0] a, input logic [15:0] s);
        return a == STATUS ? DATA_W'(s) << {a[LB-1:0], 3'b000} : '0;
    endfunction
    always_comb begin
        status = '0;
        status[STAT_FULL] = full;
        status[STAT_EMPTY] = empty;
        status[STAT_COUNT +: 8] = 8'(count);
    end
    always_comb begin
        w_next = w_state;
        axi.awready = w_state == W_IDLE;
        axi.wready = w_state == W_DATA && !full;
        axi.bvalid = w_state == W_RESP;
        axi.bid = aw_id;
        axi.bresp = resp_of(aw_addr);
        push = axi.wvalid && axi.wready && aw_addr == BASE && axi.wstrb[aw_addr[LB-1:0]];
        if (w_state == W_IDLE && axi.awvalid)
            w_next = W_DATA;
        if (w_state == W_DATA && axi.wvalid && axi.wready && axi.wlast)
            w_next = W_RESP;
        if (w_state == W_RESP && axi.bready)
            w_next = W_IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state <= W_IDLE;
            aw_addr <= '0;
            aw_id <= '0;
        end else begin
            w_state <= w_next;
            if (axi.awvalid && axi.awready) begin
                aw_addr <= axi.awaddr;
                aw_id <= axi.awid;
            end
        end
    end
    always_comb begin
        r_next = r_state;
        axi.arready = r_state == R_IDLE;
        axi.rvalid = r_state == R_DATA;
        axi.rlast = axi.rvalid && beat == ar_len;
        axi.rdata = rdata_q;
        axi.rresp = resp_of(ar_addr);
        axi.rid = ar_id;
        if (r_state == R_IDLE && axi.arvalid)
            r_next = R_DATA;
        if (axi.rvalid && axi.rready && axi.rlast)
            r_next = R_IDLE;
    end
    // rdata is captured per beat so it holds steady under rready backpressure while the FIFO drains
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= R_IDLE;
            ar_addr <= '0;
            ar_id <= '0;
            ar_len <= '0;
            beat <= '0;
            rdata_q <= '0;
        end else begin
            r_state <= r_next;
            if (axi.arvalid && axi.arready) begin
                ar_addr <= axi.araddr;
                ar_id <= axi.arid;
                ar_len <= axi.arlen;
                beat <= '0;
                rdata_q <= rd_val(axi.araddr, status);
            end else if (axi.rvalid && axi.rready && !axi.rlast) begin
                beat <= beat + 8'd1;
                rdata_q <= rd_val(ar_addr, status);
            end
        end
    end
    assign pop = !empty && div == DIV_LAST;
    assign tx_strobe = pop;
    always_ff @(posedge clk) begin
        if (reset || empty)
            div <= '0;
        else
            div <= pop ? '0 : div + DW'(1);
    end
    ysyx_23060221_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .din(axi.wdata[{aw_addr[LB-1:0], 3'b000} +: 8]),
        .pop(pop),
        .dout(tx_byte),
        .full(full),
        .empty(empty),
        .count(count)
    );
`ifdef UART_SIM_PRINT_EN
    always_ff @(posedge clk) begin
        if (tx_strobe)
            $write("%c", tx_byte);
    end
`else
`endif
endmodule

// File: tb/tb_ysyx_23060221_axi_uart_fifo.sv
// tb_ysyx_23060221_axi_uart_fifo: directed scenarios for the AXI UART FIFO with a 4-deep FIFO.
module tb_ysyx_23060221_axi_uart_fifo;
    localparam logic [31:0] BASE = 32'ha00003f8;
    localparam logic [63:0] ST_EMPTY = 64'h0000_0002_0000_0000;
    logic clk = 0;
    logic reset = 1;
    logic tx_strobe;
    logic [7:0] tx_byte;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] txq[$];
    int txt[$];
    ysyx_23060221_axi_uart_fifo_if #(.DATA_W(64), .ID_W(4)) axi();
    ysyx_23060221_axi_uart_fifo #(
        .DATA_W(64), .ID_W(4), .TX_DEPTH(4), .BAUD_DIV(4), .BASE(BASE)
    ) dut (
        .clk(clk),
        .reset(reset),
        .axi(axi),
        .tx_strobe(tx_strobe),
        .tx_byte(tx_byte)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (tx_strobe) begin
            txq.push_back(tx_byte);
            txt.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        axi.awvalid = 1; axi.awaddr = a; axi.awid = id; axi.awlen = len;
        axi.awsize = 3'd0; axi.awburst = 2'b01;
        for (int n = 0; n < 50 && !axi.awready; n++) tick(1);
        checks++;
        if (axi.awready !== 1'b1) begin errors++; $display("FAIL aw_handshake awready=%b expected 1", axi.awready); end
        tick(1);
        axi.awvalid = 0;
    endtask

    task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic last, output int hs, output bit saw_low);
        axi.wvalid = 1; axi.wdata = d; axi.wstrb = s; axi.wlast = last;
        saw_low = 0;
        for (int n = 0; n < 50 && !axi.wready; n++) begin saw_low = 1; tick(1); end
        checks++;
        if (axi.wready !== 1'b1) begin errors++; $display("FAIL w_handshake wready=%b expected 1", axi.wready); end
        tick(1);
        hs = cyc;
        axi.wvalid = 0; axi.wlast = 0;
    endtask

    task automatic b_recv(input logic [1:0] er, input logic [3:0] eid);
        axi.bready = 1;
        for (int n = 0; n < 50 && !axi.bvalid; n++) tick(1);
        checks++;
        if (axi.bvalid !== 1'b1) begin errors++; $display("FAIL b_timeout bvalid=%b expected 1", axi.bvalid); end
        checks++;
        if (axi.bresp !== er) begin errors++; $display("FAIL bresp got %b expected %b", axi.bresp, er); end
        checks++;
        if (axi.bid !== eid) begin errors++; $display("FAIL bid got %h expected %h", axi.bid, eid); end
        tick(1);
        axi.bready = 0;
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        axi.arvalid = 1; axi.araddr = a; axi.arid = id; axi.arlen = len;
        axi.arsize = 3'd3; axi.arburst = 2'b01;
        for (int n = 0; n < 50 && !axi.arready; n++) tick(1);
        checks++;
        if (axi.arready !== 1'b1) begin errors++; $display("FAIL ar_handshake arready=%b expected 1", axi.arready); end
        tick(1);
        axi.arvalid = 0;
    endtask

    task automatic r_beat(input logic [63:0] ed, input logic el, input logic [3:0] eid, input logic [1:0] er);
        axi.rready = 1;
        for (int n = 0; n < 50 && !axi.rvalid; n++) tick(1);
        checks++;
        if (axi.rvalid !== 1'b1) begin errors++; $display("FAIL r_timeout rvalid=%b expected 1", axi.rvalid); end
        checks++;
        if (axi.rdata !== ed) begin errors++; $display("FAIL rdata got %h expected %h", axi.rdata, ed); end
        checks++;
        if (axi.rlast !== el) begin errors++; $display("FAIL rlast got %b expected %b", axi.rlast, el); end
        checks++;
        if (axi.rid !== eid || axi.rresp !== er) begin
            errors++; $display("FAIL rid_rresp got %h/%b expected %h/%b", axi.rid, axi.rresp, eid, er);
        end
        tick(1);
        axi.rready = 0;
    endtask

    task automatic wait_tx(input int n);
        for (int k = 0; k < 300 && txq.size() < n; k++) tick(1);
        checks++;
        if (txq.size() != n) begin errors++; $display("FAIL tx_count got %0d expected %0d", txq.size(), n); end
    endtask

    task automatic check_idle(input string tag);
        checks++;
        if ({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast, tx_strobe} !== 7'b1100000) begin
            errors++;
            $display("FAIL %s aw/ar/w/b/r/rlast/tx got %b%b%b%b%b%b%b expected 1100000", tag,
                     axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid, axi.rlast, tx_strobe);
        end
    endtask

    task automatic test_reset();
        reset = 1;
        tick(2);
        reset = 0;
        check_idle("reset_values");
    endtask

    task automatic test_single();
        int hs;
        bit sl;
        txq.delete(); txt.delete();
        aw_send(BASE, 4'd3, 8'd0);
        w_beat(64'h41, 8'h01, 1'b1, hs, sl);
        b_recv(2'b00, 4'd3);
        wait_tx(1);
        if (txq.size() == 1) begin
            checks++;
            if (txq[0] !== 8'h41) begin errors++; $display("FAIL single_byte got %h expected 41", txq[0]); end
            checks++;
            if (txt[0] - hs < 1 || txt[0] - hs > 4) begin
                errors++; $display("FAIL single_latency got %0d cycles expected 1..4", txt[0] - hs);
            end
        end
    endtask

    task automatic test_burst();
        int hs;
        bit sl;
        logic [7:0] s [4] = '{8'h61, 8'h62, 8'h63, 8'h64};
        txq.delete(); txt.delete();
        aw_send(BASE, 4'd6, 8'd3);
        for (int i = 0; i < 4; i++) begin
            w_beat({56'h0, s[i]}, 8'h01, i == 3, hs, sl);
            if (i < 3) begin
                checks++;
                if (axi.bvalid !== 1'b0) begin errors++; $display("FAIL burst_early_b beat %0d bvalid=%b expected 0", i, axi.bvalid); end
            end
        end
        b_recv(2'b00, 4'd6);
        wait_tx(4);
        for (int i = 0; i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== s[i]) begin errors++; $display("FAIL burst_byte %0d got %h expected %h", i, txq[i], s[i]); end
            if (i > 0) begin
                checks++;
                if (txt[i] - txt[i-1] != 4) begin errors++; $display("FAIL burst_spacing %0d got %0d expected 4", i, txt[i] - txt[i-1]); end
            end
        end
    endtask

    task automatic test_full();
        int hs;
        bit sl;
        bit any_low = 0;
        txq.delete(); txt.delete();
        aw_send(BASE, 4'd1, 8'd5);
        for (int i = 0; i < 6; i++) begin
            w_beat(64'h30 + 64'(i), 8'h01, i == 5, hs, sl);
            any_low |= sl;
        end
        checks++;
        if (!any_low) begin errors++; $display("FAIL full_backpressure wready_low=%b expected 1", any_low); end
        b_recv(2'b00, 4'd1);
        wait_tx(6);
        for (int i = 0; i < txq.size(); i++) begin
            checks++;
            if (txq[i] !== 8'h30 + 8'(i)) begin errors++; $display("FAIL full_byte %0d got %h expected %h", i, txq[i], 8'h30 + 8'(i)); end
        end
    endtask

    task automatic test_read();
        ar_send(BASE + 32'd4, 4'd5, 8'd2);
        axi.rready = 0;
        tick(3);
        checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== ST_EMPTY) begin
            errors++; $display("FAIL read_hold rvalid/rdata got %b/%h expected 1/%h", axi.rvalid, axi.rdata, ST_EMPTY);
        end
        r_beat(ST_EMPTY, 1'b0, 4'd5, 2'b00);
        r_beat(ST_EMPTY, 1'b0, 4'd5, 2'b00);
        r_beat(ST_EMPTY, 1'b1, 4'd5, 2'b00);
        checks++;
        if (axi.rvalid !== 1'b0 || axi.arready !== 1'b1) begin
            errors++; $display("FAIL read_done rvalid/arready got %b/%b expected 0/1", axi.rvalid, axi.arready);
        end
        ar_send(BASE, 4'd2, 8'd0);
        r_beat(64'h0, 1'b1, 4'd2, 2'b00);
        ar_send(32'ha0000400, 4'd9, 8'd0);
        r_beat(64'h0, 1'b1, 4'd9, 2'b10);
    endtask

    task automatic test_slverr();
        int hs;
        bit sl;
        txq.delete(); txt.delete();
        aw_send(32'ha0000000, 4'd2, 8'd0);
        w_beat(64'h55, 8'hff, 1'b1, hs, sl);
        b_recv(2'b10, 4'd2);
        aw_send(BASE, 4'd1, 8'd0);
        w_beat(64'h4200, 8'h02, 1'b1, hs, sl);
        b_recv(2'b00, 4'd1);
        tick(12);
        checks++;
        if (txq.size() != 0) begin errors++; $display("FAIL slverr_no_push got %0d bytes expected 0", txq.size()); end
        ar_send(BASE + 32'd4, 4'd4, 8'd0);
        r_beat(ST_EMPTY, 1'b1, 4'd4, 2'b00);
    endtask

    task automatic test_reset_mid();
        int hs;
        bit sl;
        txq.delete(); txt.delete();
        aw_send(BASE, 4'd7, 8'd3);
        w_beat(64'h78, 8'h01, 1'b0, hs, sl);
        axi.wvalid = 1;
        axi.bready = 1;
        reset = 1;
        tick(2);
        reset = 0;
        axi.wvalid = 0;
        check_idle("reset_mid_values");
        tick(10);
        checks++;
        if (txq.size() != 0 || axi.bvalid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_flush bytes/bvalid got %0d/%b expected 0/0", txq.size(), axi.bvalid);
        end
        axi.bready = 0;
        aw_send(BASE, 4'd9, 8'd0);
        w_beat(64'h5a, 8'h01, 1'b1, hs, sl);
        b_recv(2'b00, 4'd9);
        wait_tx(1);
        if (txq.size() == 1) begin
            checks++;
            if (txq[0] !== 8'h5a) begin errors++; $display("FAIL reset_mid_byte got %h expected 5a", txq[0]); end
        end
    endtask

    initial begin
        axi.awvalid = 0; axi.awaddr = 0; axi.awid = 0; axi.awlen = 0; axi.awsize = 0; axi.awburst = 0;
        axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
        axi.arvalid = 0; axi.araddr = 0; axi.arid = 0; axi.arlen = 0; axi.arsize = 0; axi.arburst = 0;
        axi.rready = 0;
        test_reset();
        test_single();
        test_burst();
        test_full();
        test_read();
        test_slverr();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
